// File: rtl/lotr_vga_pkg.sv
// Shared constants, command record and FSM state encoding for the VGA text writer.
package lotr_vga_pkg;

    localparam int unsigned WORDS_PER_LINE = 80;
    localparam int unsigned TEXT_COLS      = 80;
    localparam int unsigned TEXT_ROWS      = 60;
    localparam int unsigned FB_WORDS       = 9600;
    localparam int unsigned FONT_ROWS      = 8;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef struct packed {
        logic       op;
        logic [6:0] chr;
        logic [6:0] col;
        logic [5:0] row;
        logic       invert;
        logic [7:0] fill;
    } t_vga_cmd;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR0,
        WR1,
        CLR
    } t_vga_wr_state;

endpackage

// File: rtl/vga_font_rom.sv
// 1024x8 glyph ROM, address = {char, glyph row}, one cycle read latency.
// Bit 0 of each byte is the leftmost pixel. Codes without a drawn glyph
// show a hollow box so missing characters are visible on screen.
module vga_font_rom
    import lotr_vga_pkg::*;
(
    input  logic       clk_i,
    input  logic [9:0] addr_i,
    output logic [7:0] data_o
);

    localparam logic [7:0] GLYPH_A [0:7] = '{
        8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00
    };

    logic [6:0] chr;
    logic [2:0] row;
    logic [7:0] rom_d;
    logic [7:0] rom_q;

    assign chr = addr_i[9:3];
    assign row = addr_i[2:0];

    // Glyph table lookup.
    always_comb begin
        rom_d = 8'h00;
        case (chr)
            7'h20:   rom_d = 8'h00;
            7'h41:   rom_d = GLYPH_A[row];
            default: rom_d = (row == 3'd0 || row == 3'(FONT_ROWS - 1)) ? 8'hFF : 8'h81;
        endcase
    end

    // Synchronous read register.
    always_ff @(posedge clk_i) begin
        rom_q <= rom_d;
    end

    assign data_o = rom_q;

endmodule

// File: rtl/vga_char_writer.sv
// Text renderer: draws 8x8 glyphs or clears the 1 bpp 640x480 frame buffer
// through the arbitrated VGA write port.
// Handshakes: a command transfers on a cycle with CmdValid && CmdReady; a
// write transfers on a cycle with VGAWrEn && VGAWrGnt, and until then the
// write address/data stay frozen and VGAWrEn stays high.
module vga_char_writer
    import lotr_vga_pkg::*;
#(
    parameter int FB_ADDR_W = 14
) (
    input  logic                 QClk,
    input  logic                 Reset,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic                 CmdOp,
    input  logic [6:0]           CmdChar,
    input  logic [6:0]           CmdCol,
    input  logic [5:0]           CmdRow,
    input  logic                 CmdInvert,
    input  logic [7:0]           CmdFill,
    input  logic                 ErrClr,
    input  logic                 VGAWrGnt,
    output logic                 VGAWrEn,
    output logic [FB_ADDR_W-1:0] VGAWrAddr,
    output logic [31:0]          VGAWrData,
    output logic [3:0]           VGAWrByteEn,
    output logic                 Busy,
    output logic                 CmdErr,
    output t_vga_wr_state        DbgState
);

    localparam logic [FB_ADDR_W-1:0] LAST_WORD = FB_ADDR_W'(FB_WORDS - 1);

    t_vga_wr_state        state_q, state_d;
    t_vga_cmd             cmd_q, cmd_in;
    logic [3:0]           fetch_cnt_q, fetch_cnt_d;
    logic [63:0]          glyph_q, glyph_d;
    logic                 wr_en_q, wr_en_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [3:0]           be_q, be_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 cmd_bad;
    logic                 wr_done;
    logic                 fetch_last;
    logic                 clr_last;
    logic [9:0]           rom_addr;
    logic [7:0]           rom_data;
    logic [FB_ADDR_W-1:0] row_ext, col_ext, wr0_addr, wr1_addr;

    assign cmd_in = '{op: CmdOp, chr: CmdChar, col: CmdCol, row: CmdRow,
                      invert: CmdInvert, fill: CmdFill};

    assign accept     = CmdValid && ready_q;
    assign cmd_bad    = (CmdOp == OP_DRAW) &&
                        ((CmdCol >= 7'(TEXT_COLS)) || (CmdRow >= 6'(TEXT_ROWS)));
    assign wr_done    = wr_en_q && VGAWrGnt;
    assign fetch_last = (fetch_cnt_q == 4'(FONT_ROWS));
    assign clr_last   = (cmd_q.op == OP_CLEAR) && (addr_q == LAST_WORD);

    // A text row spans two 4-line word rows: top half at 2*row, bottom at 2*row+1.
    assign row_ext  = FB_ADDR_W'(cmd_q.row);
    assign col_ext  = FB_ADDR_W'(cmd_q.col);
    assign wr0_addr = (row_ext << 7) + (row_ext << 5) + col_ext;
    assign wr1_addr = wr0_addr + FB_ADDR_W'(WORDS_PER_LINE);

    assign rom_addr = {cmd_q.chr, fetch_cnt_q[2:0]};

    vga_font_rom u_font_rom (
        .clk_i  (QClk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // State register.
    always_ff @(posedge QClk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (CmdOp == OP_CLEAR) state_d = CLR;
                    else if (!cmd_bad)     state_d = FETCH;
                end
            end
            FETCH:   if (fetch_last)           state_d = WR0;
            WR0:     if (wr_done)              state_d = WR1;
            WR1:     if (wr_done)              state_d = IDLE;
            CLR:     if (wr_done && clr_last)  state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Output/datapath next values: glyph assembly and the registered write port.
    always_comb begin
        fetch_cnt_d = (state_q == FETCH) ? fetch_cnt_q + 4'd1 : 4'd0;

        // ROM data for row k arrives while the counter reads k+1.
        glyph_d = glyph_q;
        if (state_q == FETCH && fetch_cnt_q != 4'd0)
            glyph_d = {rom_data ^ {8{cmd_q.invert}}, glyph_q[63:8]};

        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept && CmdOp == OP_CLEAR) begin
                    wr_en_d = 1'b1;
                    addr_d  = '0;
                    data_d  = {4{CmdFill}};
                end
            end
            FETCH: begin
                if (fetch_last) begin
                    wr_en_d = 1'b1;
                    addr_d  = wr0_addr;
                    data_d  = glyph_d[31:0];
                end
            end
            WR0: begin
                if (wr_done) begin
                    addr_d = wr1_addr;
                    data_d = glyph_q[63:32];
                end
            end
            WR1: begin
                if (wr_done) wr_en_d = 1'b0;
            end
            CLR: begin
                if (wr_done) begin
                    if (clr_last) begin
                        wr_en_d = 1'b0;
                    end else begin
                        addr_d = addr_q + FB_ADDR_W'(1);
                        data_d = {4{cmd_q.fill}};
                    end
                end
            end
            default: wr_en_d = 1'b0;
        endcase

        be_d    = wr_en_d ? 4'hF : 4'h0;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        // A new range error wins over a same-cycle clear.
        err_d   = (accept && cmd_bad) ? 1'b1 : (ErrClr ? 1'b0 : err_q);
    end

    // Datapath and output registers.
    always_ff @(posedge QClk or posedge Reset) begin
        if (Reset) begin
            cmd_q       <= '0;
            fetch_cnt_q <= 4'd0;
            glyph_q     <= '0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= 4'h0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept) cmd_q <= cmd_in;
            fetch_cnt_q <= fetch_cnt_d;
            glyph_q     <= glyph_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign CmdReady    = ready_q;
    assign VGAWrEn     = wr_en_q;
    assign VGAWrAddr   = addr_q;
    assign VGAWrData   = data_q;
    assign VGAWrByteEn = be_q;
    assign Busy        = busy_q;
    assign CmdErr      = err_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_vga_char_writer.sv
// Directed bench for vga_char_writer with a write scoreboard.
module tb_vga_char_writer;
    import lotr_vga_pkg::*;

    localparam int FB_ADDR_W = 14;
    localparam int EW        = FB_ADDR_W + 32;

    logic                 QClk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 CmdValid = 1'b0;
    logic                 CmdReady;
    logic                 CmdOp = 1'b0;
    logic [6:0]           CmdChar = '0;
    logic [6:0]           CmdCol = '0;
    logic [5:0]           CmdRow = '0;
    logic                 CmdInvert = 1'b0;
    logic [7:0]           CmdFill = '0;
    logic                 ErrClr = 1'b0;
    logic                 VGAWrGnt = 1'b1;
    logic                 VGAWrEn;
    logic [FB_ADDR_W-1:0] VGAWrAddr;
    logic [31:0]          VGAWrData;
    logic [3:0]           VGAWrByteEn;
    logic                 Busy;
    logic                 CmdErr;
    t_vga_wr_state        DbgState;

    vga_char_writer #(.FB_ADDR_W(FB_ADDR_W)) dut (
        .QClk        (QClk),
        .Reset       (Reset),
        .CmdValid    (CmdValid),
        .CmdReady    (CmdReady),
        .CmdOp       (CmdOp),
        .CmdChar     (CmdChar),
        .CmdCol      (CmdCol),
        .CmdRow      (CmdRow),
        .CmdInvert   (CmdInvert),
        .CmdFill     (CmdFill),
        .ErrClr      (ErrClr),
        .VGAWrGnt    (VGAWrGnt),
        .VGAWrEn     (VGAWrEn),
        .VGAWrAddr   (VGAWrAddr),
        .VGAWrData   (VGAWrData),
        .VGAWrByteEn (VGAWrByteEn),
        .Busy        (Busy),
        .CmdErr      (CmdErr),
        .DbgState    (DbgState)
    );

    // Clock.
    always #5 QClk = ~QClk;

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    // Reference glyph for 'A', row 0 first, bit 0 = leftmost pixel.
    logic [7:0]  font_a [0:7] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
    logic [31:0] a_w0, a_w1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard.
    logic                 prev_stall = 1'b0;
    logic [FB_ADDR_W-1:0] prev_addr = '0;
    logic [31:0]          prev_data = '0;
    int                   wr_count = 0;
    int                   busy_bad = 0;
    always @(negedge QClk) begin
        logic [EW-1:0] e;
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 64'({VGAWrEn, VGAWrAddr, VGAWrData}),
                      64'({1'b1, prev_addr, prev_data}));
            if (VGAWrEn && (!Busy || CmdReady)) busy_bad++;
            if (VGAWrEn && VGAWrGnt) begin
                wr_count++;
                check("write_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write", 64'({VGAWrByteEn, VGAWrAddr, VGAWrData}), 64'({4'hF, e}));
                end
            end
            prev_stall = VGAWrEn && !VGAWrGnt;
            prev_addr  = VGAWrAddr;
            prev_data  = VGAWrData;
        end
    end

    // Driver: present a command and hold it until accepted.
    task automatic send_cmd(input logic op, input logic [6:0] chr, input logic [6:0] col,
                            input logic [5:0] row, input logic inv, input logic [7:0] fill);
        int n = 0;
        @(posedge QClk); #1;
        CmdOp = op; CmdChar = chr; CmdCol = col; CmdRow = row;
        CmdInvert = inv; CmdFill = fill; CmdValid = 1'b1;
        @(negedge QClk);
        while (!CmdReady && n < 20000) begin
            @(negedge QClk);
            n++;
        end
        check("cmd_accept_timeout", 64'(CmdReady), 64'(1));
        @(posedge QClk); #1;
        CmdValid = 1'b0;
    endtask

    task automatic push_write(input int addr, input logic [31:0] data);
        exp_q.push_back({FB_ADDR_W'(addr), data});
    endtask

    // Wait for all expected writes, then check the block is idle again the next cycle.
    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge QClk);
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        @(negedge QClk);
        check({tag, "_ready_after"}, 64'({CmdReady, Busy, VGAWrEn}), 64'(3'b100));
    endtask

    initial begin
        int n;
        int wc;
        a_w0 = {font_a[3], font_a[2], font_a[1], font_a[0]};
        a_w1 = {font_a[7], font_a[6], font_a[5], font_a[4]};

        // Reset state.
        repeat (3) @(negedge QClk);
        check("rst_ready", 64'(CmdReady), 64'(1));
        check("rst_outputs", 64'({VGAWrEn, VGAWrAddr, VGAWrData, VGAWrByteEn}), 64'(0));
        check("rst_busy_err", 64'({Busy, CmdErr}), 64'(0));
        check("rst_state", 64'(DbgState), 64'(IDLE));
        @(posedge QClk); #1 Reset = 1'b0;

        // Draw 'A' at (0,0) with latency measurement.
        push_write(0, a_w0);
        push_write(80, a_w1);
        send_cmd(OP_DRAW, 7'h41, 7'd0, 6'd0, 1'b0, 8'h00);
        n = 0;
        do begin
            @(negedge QClk);
            n++;
        end while (!VGAWrEn && n < 40);
        check("draw_latency", 64'(n), 64'(10));
        wait_drain("draw_a", 100);

        // Inverted 'A' in the bottom-right cell.
        push_write(9519, ~a_w0);
        push_write(9599, ~a_w1);
        send_cmd(OP_DRAW, 7'h41, 7'd79, 6'd59, 1'b1, 8'h00);
        wait_drain("draw_inv", 100);

        // Grant withheld for 5 cycles at WR0.
        wc = wr_count;
        push_write(325, a_w0);
        push_write(405, a_w1);
        send_cmd(OP_DRAW, 7'h41, 7'd5, 6'd2, 1'b0, 8'h00);
        VGAWrGnt = 1'b0;
        n = 0;
        do begin
            @(negedge QClk);
            n++;
        end while (!VGAWrEn && n < 40);
        check("stall_reached_wr0", 64'(VGAWrEn), 64'(1));
        repeat (4) @(negedge QClk);
        @(posedge QClk); #1 VGAWrGnt = 1'b1;
        wait_drain("stall", 100);
        check("stall_write_count", 64'(wr_count - wc), 64'(2));

        // Out-of-range column: dropped, error flagged.
        wc = wr_count;
        send_cmd(OP_DRAW, 7'h41, 7'd80, 6'd0, 1'b0, 8'h00);
        repeat (3) @(negedge QClk);
        check("err_col_set", 64'({CmdErr, CmdReady, Busy}), 64'(3'b110));
        check("err_col_no_write", 64'(wr_count), 64'(wc));
        @(posedge QClk); #1 ErrClr = 1'b1;
        @(posedge QClk); #1 ErrClr = 1'b0;
        @(negedge QClk);
        check("err_clear", 64'(CmdErr), 64'(0));

        // Out-of-range row.
        send_cmd(OP_DRAW, 7'h41, 7'd0, 6'd60, 1'b0, 8'h00);
        @(negedge QClk);
        check("err_row_set", 64'(CmdErr), 64'(1));
        check("err_row_no_write", 64'(wr_count), 64'(wc));
        @(posedge QClk); #1 ErrClr = 1'b1;
        @(posedge QClk); #1 ErrClr = 1'b0;
        @(negedge QClk);
        check("err_clear2", 64'(CmdErr), 64'(0));

        // Error and clear in the same cycle: set wins.
        ErrClr = 1'b1;
        send_cmd(OP_DRAW, 7'h41, 7'd100, 6'd3, 1'b0, 8'h00);
        ErrClr = 1'b0;
        @(negedge QClk);
        check("err_set_wins", 64'(CmdErr), 64'(1));
        @(posedge QClk); #1 ErrClr = 1'b1;
        @(posedge QClk); #1 ErrClr = 1'b0;

        // Full clear with 0xA5.
        busy_bad = 0;
        for (int i = 0; i < int'(FB_WORDS); i++) push_write(i, 32'hA5A5A5A5);
        send_cmd(OP_CLEAR, 7'h00, 7'd0, 6'd0, 1'b0, 8'hA5);
        wait_drain("clear", 12000);
        check("clear_busy_during", 64'(busy_bad), 64'(0));

        // Clear aborted by reset at word 100.
        for (int i = 0; i < int'(FB_WORDS); i++) push_write(i, 32'h3C3C3C3C);
        send_cmd(OP_CLEAR, 7'h00, 7'd0, 6'd0, 1'b0, 8'h3C);
        n = 0;
        while (VGAWrAddr != FB_ADDR_W'(100) && n < 400) begin
            @(posedge QClk); #1;
            n++;
        end
        Reset = 1'b1;
        #1;
        check("rst_abort_wren", 64'(VGAWrEn), 64'(0));
        check("rst_abort_progress", 64'(exp_q.size() > 0 ? exp_q[0][EW-1:32] : '1), 64'(100));
        exp_q.delete();
        repeat (2) @(posedge QClk);
        #1 Reset = 1'b0;
        @(negedge QClk);
        check("rst_abort_idle", 64'({CmdReady, Busy, VGAWrEn}), 64'(3'b100));
        wc = wr_count;
        repeat (20) @(negedge QClk);
        check("rst_abort_no_writes", 64'(wr_count), 64'(wc));

        // Space at (1,1) after the abort.
        push_write(161, 32'h0);
        push_write(241, 32'h0);
        send_cmd(OP_DRAW, 7'h20, 7'd1, 6'd1, 1'b0, 8'h00);
        wait_drain("draw_space", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
